// File: rtl/maze_pkg.sv
// Shared definitions for the maze grid renderer.
//   - cell state codes and the RGB332 colour for each
//   - packet field bit positions and wall bit order {W,S,E,N}
//   - cell record layout and FSM state encoding
package maze_pkg;

  localparam int unsigned PKT_W    = 16;
  localparam int unsigned ST_W     = 4;
  localparam int unsigned WALLS_W  = 4;
  localparam int unsigned COLOUR_W = 8;

  // Packet field positions: [15:12] x, [11:8] y, [7:4] walls, [3:0] state
  localparam int unsigned PKT_X_MSB     = 15;
  localparam int unsigned PKT_X_LSB     = 12;
  localparam int unsigned PKT_Y_MSB     = 11;
  localparam int unsigned PKT_Y_LSB     = 8;
  localparam int unsigned PKT_WALLS_MSB = 7;
  localparam int unsigned PKT_WALLS_LSB = 4;
  localparam int unsigned PKT_ST_MSB    = 3;
  localparam int unsigned PKT_ST_LSB    = 0;

  // Bit positions inside the wall nibble {W,S,E,N}
  localparam int unsigned WALL_N = 0;
  localparam int unsigned WALL_E = 1;
  localparam int unsigned WALL_S = 2;
  localparam int unsigned WALL_W = 3;

  localparam logic [ST_W-1:0] ST_UNVISITED    = 4'd0;
  localparam logic [ST_W-1:0] ST_VISITED      = 4'd1;
  localparam logic [ST_W-1:0] ST_OBSTACLE     = 4'd2;
  localparam logic [ST_W-1:0] ST_TREASURE_7K  = 4'd3;
  localparam logic [ST_W-1:0] ST_TREASURE_12K = 4'd4;
  localparam logic [ST_W-1:0] ST_TREASURE_17K = 4'd5;
  localparam logic [ST_W-1:0] ST_CURRENT      = 4'd6;
  localparam logic [ST_W-1:0] ST_MAX_VALID    = 4'd6;

  localparam logic [COLOUR_W-1:0] COL_UNVISITED    = 8'hFF;
  localparam logic [COLOUR_W-1:0] COL_VISITED      = 8'hFC;
  localparam logic [COLOUR_W-1:0] COL_OBSTACLE     = 8'h3F;
  localparam logic [COLOUR_W-1:0] COL_TREASURE_7K  = 8'hE0;
  localparam logic [COLOUR_W-1:0] COL_TREASURE_12K = 8'h1C;
  localparam logic [COLOUR_W-1:0] COL_TREASURE_17K = 8'h03;
  localparam logic [COLOUR_W-1:0] COL_CURRENT      = 8'hEC;
  localparam logic [COLOUR_W-1:0] COL_WALL         = 8'h00;
  localparam logic [COLOUR_W-1:0] COL_BLACK        = 8'h00;
  localparam logic [COLOUR_W-1:0] COL_GRID         = 8'h92;

  typedef struct packed {
    logic [WALLS_W-1:0] walls;
    logic [ST_W-1:0]    state;
  } cell_rec_t;

  typedef enum logic {
    FSM_SWEEP = 1'b0,
    FSM_RUN   = 1'b1
  } fsm_state_t;

  // Fill colour for a state code; codes above ST_MAX_VALID are never stored
  function automatic logic [COLOUR_W-1:0] state_colour(input logic [ST_W-1:0] st);
    logic [COLOUR_W-1:0] c;
    case (st)
      ST_UNVISITED:    c = COL_UNVISITED;
      ST_VISITED:      c = COL_VISITED;
      ST_OBSTACLE:     c = COL_OBSTACLE;
      ST_TREASURE_7K:  c = COL_TREASURE_7K;
      ST_TREASURE_12K: c = COL_TREASURE_12K;
      ST_TREASURE_17K: c = COL_TREASURE_17K;
      ST_CURRENT:      c = COL_CURRENT;
      default:         c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/maze_grid_renderer_if.sv
// Maze packet valid/ready channel.
//   PKT_DATA  : {x, y, walls {W,S,E,N}, state}
//   PKT_VALID : packet present (master -> slave)
//   PKT_READY : slave can accept this cycle (slave -> master)
interface maze_grid_renderer_if;
  import maze_pkg::*;

  logic [PKT_W-1:0] PKT_DATA;
  logic             PKT_VALID;
  logic             PKT_READY;

  modport master (output PKT_DATA, output PKT_VALID, input PKT_READY);
  modport slave  (input PKT_DATA, input PKT_VALID, output PKT_READY);

endinterface

// File: rtl/maze_cell_colour.sv
// Combinational pixel colour for one cell lookup.
//   rec      : cell record {walls, state}
//   ox, oy   : pixel offset inside the cell
//   in_grid  : coordinate lies inside the grid
//   colour_c : RGB332 colour (walls over gridlines over fill; black off-grid)
// Optional macro MAZE_GRID_LINES_EN draws grey 1-pixel lines at ox==0 / oy==0.
module maze_cell_colour
  import maze_pkg::*;
#(
  parameter int unsigned CELL_LOG2 = 6,
  parameter int unsigned WALL_PX   = 4
) (
  input  cell_rec_t               rec,
  input  logic [CELL_LOG2-1:0]    ox,
  input  logic [CELL_LOG2-1:0]    oy,
  input  logic                    in_grid,
  output logic [COLOUR_W-1:0]     colour_c
);

  localparam logic [CELL_LOG2-1:0] WALL_LO = CELL_LOG2'(WALL_PX);
  localparam logic [CELL_LOG2-1:0] WALL_HI = CELL_LOG2'((2 ** CELL_LOG2) - WALL_PX);

  logic on_wall;

  always_comb begin
    on_wall = (rec.walls[WALL_N] && (oy <  WALL_LO)) ||
              (rec.walls[WALL_S] && (oy >= WALL_HI)) ||
              (rec.walls[WALL_W] && (ox <  WALL_LO)) ||
              (rec.walls[WALL_E] && (ox >= WALL_HI));
  end

  always_comb begin
    colour_c = COL_BLACK;
    if (!in_grid)
      colour_c = COL_BLACK;
    else if (on_wall)
      colour_c = COL_WALL;
`ifdef MAZE_GRID_LINES_EN
    else if ((ox == '0) || (oy == '0))
      colour_c = COL_GRID;
`endif
    else
      colour_c = state_colour(rec.state);
  end

endmodule

// File: rtl/maze_grid_renderer.sv
// Maze display engine: holds a ROWS x COLS grid of {walls, state} records,
// updated from maze packets, and renders an RGB332 colour per VGA pixel.
//   CLOCK, RESET_N : pixel clock, async active-low reset
//   CLEAR          : re-sweep the grid to empty
//   pkt            : packet channel (slave modport)
//   PIXEL_X/Y      : coordinate from the VGA driver
//   PIXEL_COLOR    : colour for the coordinate presented 2 cycles earlier
//   ERR_COUNT      : saturating count of dropped packets
//   BUSY           : clear sweep in progress
// Optional macro MAZE_GRID_LINES_EN enables 1-pixel grey cell gridlines.
module maze_grid_renderer
  import maze_pkg::*;
#(
  parameter int unsigned COLS      = 4,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned CELL_LOG2 = 6,
  parameter int unsigned WALL_PX   = 4,
  parameter int unsigned COORD_W   = 10
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  input  logic                 CLEAR,
  maze_grid_renderer_if.slave  pkt,
  input  logic [COORD_W-1:0]   PIXEL_X,
  input  logic [COORD_W-1:0]   PIXEL_Y,
  output logic [COLOUR_W-1:0]  PIXEL_COLOR,
  output logic [7:0]           ERR_COUNT,
  output logic                 BUSY
);

  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned CC_W  = COORD_W - CELL_LOG2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  // ---------------- control FSM ----------------
  fsm_state_t       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic             ready_q, ready_d;
  logic             busy_d;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= FSM_SWEEP;
      sweep_q <= '0;
      ready_q <= 1'b0;
      BUSY    <= 1'b1;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      BUSY    <= busy_d;
    end
  end

  // Ready/busy are registered from the next state so they track state_q exactly
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    case (state_q)
      FSM_SWEEP: begin
        if (CLEAR) begin
          sweep_d = '0;
        end else if (sweep_q == LAST_IDX) begin
          state_d = FSM_RUN;
          sweep_d = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      FSM_RUN: begin
        if (CLEAR) begin
          state_d = FSM_SWEEP;
          sweep_d = '0;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = FSM_SWEEP;
        sweep_d = '0;
      end
    endcase
  end

  assign pkt.PKT_READY = ready_q;

  // ---------------- packet decode ----------------
  logic [3:0]       pkt_x, pkt_y;
  logic [3:0]       pkt_walls, pkt_state;
  logic             pkt_fire, pkt_bad;
  logic [IDX_W-1:0] pkt_idx;

  assign pkt_x     = pkt.PKT_DATA[PKT_X_MSB:PKT_X_LSB];
  assign pkt_y     = pkt.PKT_DATA[PKT_Y_MSB:PKT_Y_LSB];
  assign pkt_walls = pkt.PKT_DATA[PKT_WALLS_MSB:PKT_WALLS_LSB];
  assign pkt_state = pkt.PKT_DATA[PKT_ST_MSB:PKT_ST_LSB];

  // A CLEAR in the same cycle wins over the handshake
  assign pkt_fire = pkt.PKT_VALID && ready_q && !CLEAR;
  assign pkt_bad  = (32'(pkt_x) >= COLS) || (32'(pkt_y) >= ROWS) ||
                    (pkt_state > ST_MAX_VALID);
  assign pkt_idx  = IDX_W'(32'(pkt_y) * COLS + 32'(pkt_x));

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      ERR_COUNT <= 8'd0;
    else if (pkt_fire && pkt_bad && (ERR_COUNT != 8'hFF))
      ERR_COUNT <= ERR_COUNT + 8'd1;
  end

  // ---------------- grid storage (no reset, RAM-style) ----------------
  cell_rec_t        grid [CELLS];
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  cell_rec_t        wr_rec;

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = sweep_q;
    wr_rec = '0;
    if (state_q == FSM_SWEEP) begin
      wr_en = 1'b1;
    end else if (pkt_fire && !pkt_bad) begin
      wr_en  = 1'b1;
      wr_idx = pkt_idx;
      wr_rec = '{walls: pkt_walls, state: pkt_state};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en)
      grid[wr_idx] <= wr_rec;
  end

  // ---------------- pixel pipeline S1: split coordinate ----------------
  logic [CC_W-1:0]      cx, cy;
  logic [CC_W-1:0]      cx_q, cy_q;
  logic [CELL_LOG2-1:0] ox_q, oy_q;
  logic                 in_grid_q;

  assign cx = PIXEL_X[COORD_W-1:CELL_LOG2];
  assign cy = PIXEL_Y[COORD_W-1:CELL_LOG2];

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cx_q      <= '0;
      cy_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      in_grid_q <= 1'b0;
    end else begin
      cx_q      <= cx;
      cy_q      <= cy;
      ox_q      <= PIXEL_X[CELL_LOG2-1:0];
      oy_q      <= PIXEL_Y[CELL_LOG2-1:0];
      in_grid_q <= (32'(cx) < COLS) && (32'(cy) < ROWS);
    end
  end

  // ---------------- pixel pipeline S2: lookup and colour ----------------
  logic [IDX_W-1:0]    rd_idx;
  cell_rec_t           rd_rec;
  logic [COLOUR_W-1:0] colour_c;

  // Off-grid lookups are steered to index 0; their colour is forced black anyway
  assign rd_idx = in_grid_q ? IDX_W'(32'(cy_q) * COLS + 32'(cx_q)) : '0;
  assign rd_rec = grid[rd_idx];

  maze_cell_colour #(
    .CELL_LOG2 (CELL_LOG2),
    .WALL_PX   (WALL_PX)
  ) u_cell_colour (
    .rec      (rd_rec),
    .ox       (ox_q),
    .oy       (oy_q),
    .in_grid  (in_grid_q),
    .colour_c (colour_c)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      PIXEL_COLOR <= COL_BLACK;
    else if (state_q == FSM_SWEEP)
      PIXEL_COLOR <= COL_BLACK;
    else
      PIXEL_COLOR <= colour_c;
  end

endmodule

// File: tb/tb_maze_grid_renderer.sv
// Directed bench for maze_grid_renderer (default parameters, 4x5 cells of 64 px).
module tb_maze_grid_renderer;

  logic       CLOCK;
  logic       RESET_N;
  logic       CLEAR;
  logic [9:0] PIXEL_X, PIXEL_Y;
  logic [7:0] PIXEL_COLOR;
  logic [7:0] ERR_COUNT;
  logic       BUSY;

  maze_grid_renderer_if pkt_bus ();

  maze_grid_renderer dut (
    .CLOCK       (CLOCK),
    .RESET_N     (RESET_N),
    .CLEAR       (CLEAR),
    .pkt         (pkt_bus),
    .PIXEL_X     (PIXEL_X),
    .PIXEL_Y     (PIXEL_Y),
    .PIXEL_COLOR (PIXEL_COLOR),
    .ERR_COUNT   (ERR_COUNT),
    .BUSY        (BUSY)
  );

  initial CLOCK = 1'b0;
  always #20 CLOCK = ~CLOCK;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_pkt;   // 1: send packet and check ERR_COUNT; 0: pixel lookup
    logic [15:0] data;
    int          px;
    int          py;
    logic [7:0]  exp;      // expected ERR_COUNT or PIXEL_COLOR
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit p, logic [15:0] d, int x, int y, logic [7:0] e, string n);
    vec_t v;
    v.is_pkt = p; v.data = d; v.px = x; v.py = y; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Present a coordinate at a negedge; colour is valid after the second rising edge
  task automatic pix(input int x, input int y, input logic [7:0] e, input string n);
    PIXEL_X = 10'(x);
    PIXEL_Y = 10'(y);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    check(n, 32'(PIXEL_COLOR), 32'(e));
  endtask

  task automatic send(input logic [15:0] d);
    pkt_bus.PKT_DATA  = d;
    pkt_bus.PKT_VALID = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    pkt_bus.PKT_VALID = 1'b0;
  endtask

  logic [7:0] grid_exp;
  int         cnt;

  initial begin
    RESET_N = 1'b0;
    CLEAR   = 1'b0;
    PIXEL_X = '0;
    PIXEL_Y = '0;
    pkt_bus.PKT_DATA  = '0;
    pkt_bus.PKT_VALID = 1'b0;

`ifdef MAZE_GRID_LINES_EN
    grid_exp = 8'h92;
`else
    grid_exp = 8'hFF;
`endif

    // Vector table: packets with expected error count, pixels with expected colour
    add(0, 16'h0000,  10,  70, 8'hFF, "init_fill");
    add(1, 16'h2306,   0,   0, 8'd0,  "pkt_current_err");
    add(0, 16'h0000, 150, 220, 8'hEC, "current_fill");
    add(0, 16'h0000, 100, 220, 8'hFF, "neighbour_fill");
    add(1, 16'h0031,   0,   0, 8'd0,  "pkt_ne_err");
    add(0, 16'h0000,  30,   2, 8'h00, "n_wall");
    add(0, 16'h0000,  62,  30, 8'h00, "e_wall");
    add(0, 16'h0000,  30,  30, 8'hFC, "visited_fill");
    add(0, 16'h0000,   2,  30, 8'hFC, "no_w_wall");
    add(0, 16'h0000,  59,  30, 8'hFC, "e_wall_edge_minus1");
    add(1, 16'h4001,   0,   0, 8'd1,  "drop_x");
    add(1, 16'h0501,   0,   0, 8'd2,  "drop_y");
    add(1, 16'h1107,   0,   0, 8'd3,  "drop_state7");
    add(0, 16'h0000, 100, 100, 8'hFF, "drop_no_change");
    add(0, 16'h0000, 300,  10, 8'h00, "right_of_grid");
    add(0, 16'h0000,  10, 400, 8'h00, "below_grid");
    add(0, 16'h0000, 256,   0, 8'h00, "first_col_outside");
    add(1, 16'h1103,   0,   0, 8'd3,  "pkt_t7k_err");
    add(0, 16'h0000, 100, 100, 8'hE0, "t7k_fill");
    add(1, 16'h3404,   0,   0, 8'd3,  "pkt_t12k_err");
    add(0, 16'h0000, 220, 290, 8'h1C, "t12k_fill");
    add(0, 16'h0000, 255, 319, 8'h1C, "last_pixel_in_grid");
    add(1, 16'h2002,   0,   0, 8'd3,  "pkt_obstacle_err");
    add(0, 16'h0000, 150,  30, 8'h3F, "obstacle_fill");
    add(1, 16'h3145,   0,   0, 8'd3,  "pkt_s_wall_err");
    add(0, 16'h0000, 220, 124, 8'h00, "s_wall");
    add(0, 16'h0000, 220, 123, 8'h03, "s_wall_edge_minus1");
    add(1, 16'h0085,   0,   0, 8'd3,  "pkt_overwrite_err");
    add(0, 16'h0000,   2,  30, 8'h00, "w_wall");
    add(0, 16'h0000,  30,   2, 8'h03, "n_wall_removed");
    add(0, 16'h0000,  62,  30, 8'h03, "e_wall_removed");
    add(0, 16'h0000,  64,  30, grid_exp, "gridline_pixel");

    // Reset state
    repeat (3) @(negedge CLOCK);
    check("rst_busy",   32'(BUSY), 32'd1);
    check("rst_ready",  32'(pkt_bus.PKT_READY), 32'd0);
    check("rst_colour", 32'(PIXEL_COLOR), 32'h00);
    check("rst_err",    32'(ERR_COUNT), 32'd0);

    // Initial sweep: BUSY for exactly 20 cycles, then ready
    RESET_N = 1'b1;
    cnt = 0;
    while (BUSY && cnt < 100) begin
      cnt++;
      @(negedge CLOCK);
    end
    check("init_busy_cycles", 32'(cnt), 32'd20);
    check("init_ready", 32'(pkt_bus.PKT_READY), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_pkt) begin
        send(vecs[i].data);
        check(vecs[i].name, 32'(ERR_COUNT), 32'(vecs[i].exp));
      end else begin
        pix(vecs[i].px, vecs[i].py, vecs[i].exp, vecs[i].name);
      end
    end

    // Error counter saturation with a stream of bad packets
    pkt_bus.PKT_DATA  = 16'h0007;
    pkt_bus.PKT_VALID = 1'b1;
    repeat (200) @(posedge CLOCK);
    @(negedge CLOCK);
    check("err_mid_stream", 32'(ERR_COUNT), 32'd203);
    repeat (100) @(posedge CLOCK);
    @(negedge CLOCK);
    pkt_bus.PKT_VALID = 1'b0;
    check("err_saturated", 32'(ERR_COUNT), 32'd255);

    // CLEAR in RUN with a packet held valid across the whole sweep
    PIXEL_X = 10'd32;
    PIXEL_Y = 10'd32;
    pkt_bus.PKT_DATA  = 16'h1206;
    pkt_bus.PKT_VALID = 1'b1;
    CLEAR = 1'b1;
    @(negedge CLOCK);
    CLEAR = 1'b0;
    cnt = 0;
    while (!pkt_bus.PKT_READY && cnt < 100) begin
      cnt++;
      check("clear_busy", 32'(BUSY), 32'd1);
      if (cnt >= 2)
        check("sweep_black", 32'(PIXEL_COLOR), 32'h00);
      @(negedge CLOCK);
    end
    check("clear_ready_low_cycles", 32'(cnt), 32'd20);
    @(posedge CLOCK);
    @(negedge CLOCK);
    pkt_bus.PKT_VALID = 1'b0;
    check("err_kept_after_clear", 32'(ERR_COUNT), 32'd255);

    // Only the held packet's cell (1,2) differs from empty after the sweep
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 4; x++) begin
        pix(x * 64 + 32, y * 64 + 32, (x == 1 && y == 2) ? 8'hEC : 8'hFF, "post_clear_cell");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
